// File: rtl/im_compr_ctrl.sv
// im_compr_ctrl: frame sequencer that issues one datapath start per output tile and writes each result (optional watchdog: IM_COMPR_CTRL_WDT_EN)
module im_compr_ctrl #(
    parameter int pIN_IM_WIDTH  = 640,
    parameter int pIN_IM_HEIGHT = 480,
    parameter int pAREA_WIDTH   = 4,
    parameter int pAREA_HEIGHT  = 4,
    parameter int pWDT_CYCLES   = 1024,
    localparam int OUT_W  = pIN_IM_WIDTH / pAREA_WIDTH,
    localparam int OUT_H  = pIN_IM_HEIGHT / pAREA_HEIGHT,
    localparam int AW_IN  = $clog2(pIN_IM_WIDTH * pIN_IM_HEIGHT),
    localparam int AW_OUT = $clog2(OUT_W * OUT_H)
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              iframe_start,
    input  logic [AW_IN-1:0]  iframe_base,
    input  logic              iabort,
    output logic              oframe_busy,
    output logic              oframe_done,
    output logic              oframe_ovr,
    output logic              ostart_work,
    output logic [AW_IN-1:0]  odata_start_ptr,
    input  logic              iwork_f,
    input  logic              idone_f,
    output logic              omem_wr_en,
    output logic [AW_OUT-1:0] oaddr_wr,
    output logic              oerr_timeout
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam int TXW = OUT_W > 1 ? $clog2(OUT_W) : 1;
    localparam int TYW = OUT_H > 1 ? $clog2(OUT_H) : 1;
    localparam logic [AW_IN-1:0] COL_STEP = AW_IN'(pAREA_WIDTH);
    localparam logic [AW_IN-1:0] ROW_STEP = AW_IN'(pAREA_HEIGHT * pIN_IM_WIDTH);

    logic [2:0]        state, state_nxt;
    logic [AW_IN-1:0]  ptr, row_base;
    logic [TXW-1:0]    tx;
    logic [TYW-1:0]    ty;
    logic [AW_OUT-1:0] tile_idx;
    logic              last_col, last_tile;
    logic              accept, kill, got_done, timeout, wdt_fire, advance;
    logic              unused;

    // The datapath busy flag is only observed, never acted upon.
    assign unused = ^{iwork_f, pWDT_CYCLES};

    assign last_col  = tx == TXW'(OUT_W - 1);
    assign last_tile = last_col && ty == TYW'(OUT_H - 1);
    assign accept    = state == S_IDLE && iframe_start;
    assign kill      = state != S_IDLE && iabort;
    assign got_done  = state == S_WAIT && idone_f && !kill;
    assign wdt_fire  = timeout && !kill;
    assign advance   = state == S_WRITE && !kill;

`ifdef IM_COMPR_CTRL_WDT_EN
    localparam int WW = $clog2(pWDT_CYCLES + 1);
    logic [WW-1:0] wdt_cnt;

    // Count cycles spent in WAIT; leaving WAIT clears it so each tile starts fresh.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst)
            wdt_cnt <= '0;
        else if (state != S_WAIT)
            wdt_cnt <= '0;
        else
            wdt_cnt <= wdt_cnt + WW'(1);
    end

    // A done on the final allowed cycle still wins over the watchdog.
    assign timeout = state == S_WAIT && !idone_f && wdt_cnt == WW'(pWDT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif

    // Next-state selection; abort pulls any active frame straight back to IDLE.
    always_comb begin
        state_nxt = state;
        if (kill)
            state_nxt = S_IDLE;
        else
            case (state)
                S_IDLE:  state_nxt = iframe_start ? S_ISSUE : S_IDLE;
                S_ISSUE: state_nxt = S_WAIT;
                S_WAIT:  state_nxt = idone_f ? S_WRITE : (timeout ? S_IDLE : S_WAIT);
                S_WRITE: state_nxt = last_tile ? S_DONE : S_ISSUE;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
    end

    // State register.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Tile walk: column step inside a row, row step at the right edge; frozen after the last tile.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            ptr      <= '0;
            row_base <= '0;
            tx       <= '0;
            ty       <= '0;
            tile_idx <= '0;
        end else if (accept) begin
            ptr      <= iframe_base;
            row_base <= iframe_base;
            tx       <= '0;
            ty       <= '0;
            tile_idx <= '0;
        end else if (advance && !last_tile) begin
            tile_idx <= tile_idx + AW_OUT'(1);
            if (last_col) begin
                tx       <= '0;
                ty       <= ty + TYW'(1);
                row_base <= row_base + ROW_STEP;
                ptr      <= row_base + ROW_STEP;
            end else begin
                tx  <= tx + TXW'(1);
                ptr <= ptr + COL_STEP;
            end
        end
    end

    // Registered pulses and frame status; the write strobe is raised on the done edge itself.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            oframe_busy     <= 1'b0;
            oframe_done     <= 1'b0;
            oframe_ovr      <= 1'b0;
            ostart_work     <= 1'b0;
            odata_start_ptr <= '0;
            omem_wr_en      <= 1'b0;
            oaddr_wr        <= '0;
            oerr_timeout    <= 1'b0;
        end else begin
            oframe_ovr   <= iframe_start && oframe_busy && !oframe_ovr;
            ostart_work  <= state == S_ISSUE && !kill;
            omem_wr_en   <= got_done;
            oframe_done  <= state == S_DONE && !kill;
            oerr_timeout <= wdt_fire;
            if (state == S_ISSUE && !kill)
                odata_start_ptr <= ptr;
            if (got_done)
                oaddr_wr <= tile_idx;
            if (accept)
                oframe_busy <= 1'b1;
            else if (kill || wdt_fire || state == S_DONE)
                oframe_busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_im_compr_ctrl.sv
// tb_im_compr_ctrl: randomized self-checking bench for im_compr_ctrl on a 16x8 frame with 4x4 tiles
module tb_im_compr_ctrl;
    localparam int W = 16, H = 8, AWD = 4, AHT = 4, WDT = 16;
    localparam int OW = W / AWD, OH = H / AHT, NT = OW * OH;
    localparam int AI = $clog2(W * H), AO = $clog2(NT);

    logic iclk = 0, irst = 0, iframe_start = 0, iabort = 0, iwork_f = 0;
    logic model_done = 0, stray_done = 0;
    logic [AI-1:0] iframe_base = '0;
    logic idone_f;
    logic oframe_busy, oframe_done, oframe_ovr, ostart_work, omem_wr_en, oerr_timeout;
    logic [AI-1:0] odata_start_ptr;
    logic [AO-1:0] oaddr_wr;

    assign idone_f = model_done | stray_done;

    im_compr_ctrl #(
        .pIN_IM_WIDTH(W), .pIN_IM_HEIGHT(H), .pAREA_WIDTH(AWD), .pAREA_HEIGHT(AHT), .pWDT_CYCLES(WDT)
    ) dut (
        .iclk(iclk), .irst(irst), .iframe_start(iframe_start), .iframe_base(iframe_base),
        .iabort(iabort), .oframe_busy(oframe_busy), .oframe_done(oframe_done),
        .oframe_ovr(oframe_ovr), .ostart_work(ostart_work), .odata_start_ptr(odata_start_ptr),
        .iwork_f(iwork_f), .idone_f(idone_f), .omem_wr_en(omem_wr_en), .oaddr_wr(oaddr_wr),
        .oerr_timeout(oerr_timeout)
    );

    always #5 iclk = ~iclk;

    int checks = 0, passed = 0;
    int lat = 3, cnt = 0, n_idone = 0, abort_at = 0;
    bit resp_en = 1;
    int cyc = 0, n_fdone = 0, n_ovr = 0, viol = 0;
    int q_ptr[$], q_addr[$], q_dcyc[$], q_wcyc[$], q_scyc[$], q_tcyc[$];
    logic [4:0] prev = '0;

    // Datapath model: answers each start with a done pulse lat cycles later; may abort on the Nth done.
    initial forever begin
        @(negedge iclk);
        model_done = 0;
        iabort = 0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                model_done = 1;
                n_idone++;
                if (n_idone == abort_at) iabort = 1;
            end
        end
        if (ostart_work && resp_en) cnt = lat;
        iwork_f = cnt > 0;
    end

    // Event recorder, sampling mid-cycle once all inputs and outputs are settled.
    initial forever begin
        @(negedge iclk);
        #1;
        cyc++;
        if (ostart_work) begin q_ptr.push_back(int'(odata_start_ptr)); q_scyc.push_back(cyc); end
        if (omem_wr_en) begin q_addr.push_back(int'(oaddr_wr)); q_wcyc.push_back(cyc); end
        if (idone_f) q_dcyc.push_back(cyc);
        if (oerr_timeout) q_tcyc.push_back(cyc);
        if (oframe_done) n_fdone++;
        if (oframe_ovr) n_ovr++;
        if (|({ostart_work, omem_wr_en, oframe_done, oframe_ovr, oerr_timeout} & prev)) viol++;
        prev = {ostart_work, omem_wr_en, oframe_done, oframe_ovr, oerr_timeout};
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d want finish", cyc);
        $fatal(1);
    end

    function automatic int exp_ptr(input int base, input int k);
        return (base + (k / OW) * AHT * W + (k % OW) * AWD) % (1 << AI);
    endfunction

    task automatic clr();
        q_ptr.delete(); q_addr.delete(); q_dcyc.delete(); q_wcyc.delete(); q_scyc.delete(); q_tcyc.delete();
        n_fdone = 0; n_ovr = 0; n_idone = 0; abort_at = 0; viol = 0;
    endtask

    task automatic kick(input int base, output int t0);
        @(negedge iclk);
        iframe_base = AI'(base);
        iframe_start = 1;
        #2 t0 = cyc;
        @(negedge iclk);
        iframe_start = 0;
    endtask

    task automatic wait_idle(output bit ok, output int t);
        ok = 0;
        t = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge iclk);
            #2;
            if (!oframe_busy) begin ok = 1; t = cyc; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge iclk);
        checks++;
        if ({oframe_busy, oframe_done, oframe_ovr, ostart_work, odata_start_ptr, omem_wr_en, oaddr_wr, oerr_timeout} !== '0)
            $display("FAIL reset_outputs got busy=%b start=%b ptr=%0d wr=%b addr=%0d want all 0", oframe_busy, ostart_work, odata_start_ptr, omem_wr_en, oaddr_wr);
        else passed++;
        irst = 1;
        repeat (3) @(negedge iclk);
        #2;
        checks++;
        if ({oframe_busy, ostart_work, omem_wr_en, oframe_done, oerr_timeout} !== 5'b0)
            $display("FAIL idle_after_reset got busy=%b start=%b wr=%b want 0", oframe_busy, ostart_work, omem_wr_en);
        else passed++;
    endtask

    task automatic test_frame(input int base, input int l, input string nm);
        bit ok;
        int t0, t;
        clr();
        lat = l;
        kick(base, t0);
        wait_idle(ok, t);
        checks++;
        if (!ok) $display("FAIL %s_idle busy=%b want 0 within budget", nm, oframe_busy); else passed++;
        checks++;
        if (q_ptr.size() != NT || q_addr.size() != NT)
            $display("FAIL %s_counts starts=%0d writes=%0d want %0d", nm, q_ptr.size(), q_addr.size(), NT);
        else passed++;
        for (int k = 0; k < NT && k < q_ptr.size(); k++) begin
            checks++;
            if (q_ptr[k] != exp_ptr(base, k)) $display("FAIL %s_ptr[%0d] got %0d want %0d", nm, k, q_ptr[k], exp_ptr(base, k));
            else passed++;
        end
        for (int k = 0; k < NT && k < q_addr.size(); k++) begin
            checks++;
            if (q_addr[k] != k) $display("FAIL %s_addr[%0d] got %0d want %0d", nm, k, q_addr[k], k);
            else passed++;
        end
        for (int k = 0; k < q_wcyc.size() && k < q_dcyc.size(); k++) begin
            checks++;
            if (q_wcyc[k] != q_dcyc[k] + 1) $display("FAIL %s_wr_lat[%0d] got %0d want %0d", nm, k, q_wcyc[k], q_dcyc[k] + 1);
            else passed++;
        end
        checks++;
        if (q_scyc.size() == 0 || q_scyc[0] != t0 + 2)
            $display("FAIL %s_first_start cyc got %0d want %0d", nm, q_scyc.size() ? q_scyc[0] : -1, t0 + 2);
        else passed++;
        checks++;
        if (n_fdone != 1 || q_tcyc.size() != 0 || viol != 0)
            $display("FAIL %s_pulses done=%0d tmo=%0d viol=%0d want 1 0 0", nm, n_fdone, q_tcyc.size(), viol);
        else passed++;
    endtask

    task automatic test_overrun();
        bit ok;
        int t0, t;
        clr();
        lat = 3;
        kick(0, t0);
        for (int i = 0; i < 200 && q_ptr.size() < 3; i++) begin @(negedge iclk); #2; end
        @(negedge iclk);
        iframe_base = AI'(40);
        iframe_start = 1;
        @(negedge iclk);
        iframe_start = 0;
        wait_idle(ok, t);
        checks++;
        if (!ok || n_ovr != 1) $display("FAIL ovr_count got %0d idle=%b want 1 1", n_ovr, ok); else passed++;
        checks++;
        if (q_addr.size() != NT || n_fdone != 1 || viol != 0)
            $display("FAIL ovr_frame writes=%0d done=%0d viol=%0d want %0d 1 0", q_addr.size(), n_fdone, viol, NT);
        else passed++;
        for (int k = 0; k < q_ptr.size(); k++) begin
            checks++;
            if (q_ptr[k] != exp_ptr(0, k)) $display("FAIL ovr_ptr[%0d] got %0d want %0d", k, q_ptr[k], exp_ptr(0, k));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        clr();
        lat = 2;
        kick(8, t0);
        for (int i = 0; i < 200 && q_addr.size() < NT; i++) begin @(negedge iclk); #2; end
        @(negedge iclk);
        iframe_start = 1;
        @(negedge iclk);
        iframe_start = 0;
        #2;
        checks++;
        if ({oframe_done, oframe_ovr, oframe_busy} !== 3'b110)
            $display("FAIL b2b_edge got done=%b ovr=%b busy=%b want 1 1 0", oframe_done, oframe_ovr, oframe_busy);
        else passed++;
        repeat (6) @(negedge iclk);
        #2;
        checks++;
        if (q_ptr.size() != NT || oframe_busy !== 1'b0)
            $display("FAIL b2b_dropped starts=%0d busy=%b want %0d 0", q_ptr.size(), oframe_busy, NT);
        else passed++;
    endtask

    task automatic test_abort();
        bit ok;
        int t0, t, base;
        clr();
        lat = 3;
        abort_at = 5;
        kick(24, t0);
        wait_idle(ok, t);
        checks++;
        if (!ok || q_addr.size() != 4 || n_fdone != 0)
            $display("FAIL abort_effect writes=%0d done=%0d idle=%b want 4 0 1", q_addr.size(), n_fdone, ok);
        else passed++;
        checks++;
        if (q_dcyc.size() < 5 || t != q_dcyc[4] + 1)
            $display("FAIL abort_busy_fall cyc got %0d want %0d", t, q_dcyc.size() >= 5 ? q_dcyc[4] + 1 : -1);
        else passed++;
        repeat (4) @(negedge iclk);
        #2;
        checks++;
        if (q_addr.size() != 4 || q_ptr.size() != 5)
            $display("FAIL abort_quiet writes=%0d starts=%0d want 4 5", q_addr.size(), q_ptr.size());
        else passed++;
        base = $urandom_range(0, 63);
        test_frame(base, 3, "restart");
    endtask

    task automatic test_reset_mid();
        int t0;
        clr();
        lat = 6;
        kick(0, t0);
        for (int i = 0; i < 50 && q_ptr.size() < 1; i++) begin @(negedge iclk); #2; end
        @(posedge iclk);
        #3 irst = 0;
        #1;
        checks++;
        if ({oframe_busy, oframe_done, oframe_ovr, ostart_work, odata_start_ptr, omem_wr_en, oaddr_wr, oerr_timeout} !== '0)
            $display("FAIL async_reset got busy=%b ptr=%0d addr=%0d want all 0", oframe_busy, odata_start_ptr, oaddr_wr);
        else passed++;
        repeat (2) @(negedge iclk);
        irst = 1;
        clr();
        @(negedge iclk);
        stray_done = 1;
        @(negedge iclk);
        stray_done = 0;
        repeat (8) @(negedge iclk);
        #2;
        checks++;
        if (q_addr.size() != 0 || q_ptr.size() != 0 || oframe_busy !== 1'b0 || n_fdone != 0)
            $display("FAIL stray_done writes=%0d starts=%0d busy=%b want 0 0 0", q_addr.size(), q_ptr.size(), oframe_busy);
        else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++)
            test_frame($urandom_range(0, (1 << AI) - 1), $urandom_range(1, 6), "rand");
    endtask

`ifdef IM_COMPR_CTRL_WDT_EN
    task automatic test_wdt();
        bit ok;
        int t0, t;
        clr();
        resp_en = 0;
        kick(0, t0);
        wait_idle(ok, t);
        checks++;
        if (!ok || q_tcyc.size() != 1 || q_scyc.size() != 1 || q_tcyc[0] != q_scyc[0] + WDT)
            $display("FAIL wdt_pulse cyc got %0d want %0d", q_tcyc.size() ? q_tcyc[0] : -1, q_scyc.size() ? q_scyc[0] + WDT : -1);
        else passed++;
        checks++;
        if (q_addr.size() != 0 || n_fdone != 0 || oframe_busy !== 1'b0)
            $display("FAIL wdt_abandon writes=%0d done=%0d busy=%b want 0 0 0", q_addr.size(), n_fdone, oframe_busy);
        else passed++;
        resp_en = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_frame(0, 3, "base0");
        test_frame(100, 3, "base100");
        test_overrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
`ifdef IM_COMPR_CTRL_WDT_EN
        test_wdt();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
